issue_queue: RTL and testbench

In-order instruction issue queue feeding the adder reservation station of the Tomasulo core. It buffers 16-bit instructions from fetch/decode, decodes the opcode class, and drives the adder RS `instruction`/`Adderin` pair only when the RS `Busy` vector shows a free line. It accounts for the one-cycle lag between `Adderin` and `Busy`. Non-adder instructions leave through a valid/ready port toward the other functional-unit stations.

---
 rtl/issue_queue.sv | 115 +++++++++++
 tb/tb_issue_queue.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/issue_queue.sv
// In-order issue queue: buffers decoded instructions, issues ADD/SUB to the adder RS
// and everything else to a valid/ready stage. Optional macro: ISSUEQ_BYPASS_EN.
module issue_queue #(
  parameter int DEPTH   = 8,
  parameter int INSTR_W = 16
) (
  input  logic                       Clock,
  input  logic                       Resetn,
  input  logic [INSTR_W-1:0]         InstrIn,
  input  logic                       InstrValid,
  output logic                       InstrReady,
  input  logic [7:0]                 Busy,
  output logic [INSTR_W-1:0]         AdderInstr,
  output logic                       Adderin,
  output logic [INSTR_W-1:0]         OtherInstr,
  output logic                       OtherValid,
  input  logic                       OtherReady,
  output logic [$clog2(DEPTH):0]     Count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Handshakes: InstrIn transfers on an edge with InstrValid && InstrReady;
  // OtherInstr transfers on an edge with OtherValid && OtherReady, and while
  // OtherValid && !OtherReady the stage holds OtherValid/OtherInstr unchanged.

  logic [INSTR_W-1:0] mem [DEPTH];
  logic [PW-1:0]      rd_ptr, wr_ptr;
  logic [CW-1:0]      count_q;

  logic [3:0]         idle_lines;
  logic signed [4:0]  free_s;
  logic               free_avail;
  logic [INSTR_W-1:0] head;
  logic               head_adder, not_empty, other_free;
  logic               push, wr_en, pop_adder, pop_other, pop;
  logic               byp_adder, byp_other, issue_adder, issue_other;
  logic [INSTR_W-1:0] issue_data;

  function automatic logic is_adder_op(input logic [INSTR_W-1:0] ins);
    return (ins[INSTR_W-1 -: 4] == 4'h0) || (ins[INSTR_W-1 -: 4] == 4'h1);
  endfunction

  always_comb begin
    idle_lines = '0;
    for (int i = 0; i < 8; i++) idle_lines = idle_lines + {3'b000, ~Busy[i]};
  end

  // One bit wider than the nominal 4-bit signed value so an all-idle RS (8) stays positive.
  // Subtracting Adderin accounts for the issue already in flight but not yet in Busy.
  assign free_s     = $signed({1'b0, idle_lines}) - $signed({4'b0000, Adderin});
  assign free_avail = free_s > 5'sd0;

  assign head       = mem[rd_ptr];
  assign head_adder = is_adder_op(head);
  assign not_empty  = count_q != '0;
  assign other_free = !OtherValid || OtherReady;
  assign InstrReady = count_q != CW'(DEPTH);
  assign Count      = count_q;

  assign push       = InstrValid && InstrReady;
  assign pop_adder  = not_empty && head_adder && free_avail;
  assign pop_other  = not_empty && !head_adder && other_free;
  assign pop        = pop_adder || pop_other;

`ifdef ISSUEQ_BYPASS_EN
  // Empty queue: an instruction whose target can take it skips storage entirely.
  assign byp_adder  = push && !not_empty && is_adder_op(InstrIn) && free_avail;
  assign byp_other  = push && !not_empty && !is_adder_op(InstrIn) && other_free;
`else
  assign byp_adder  = 1'b0;
  assign byp_other  = 1'b0;
`endif

  assign wr_en       = push && !byp_adder && !byp_other;
  assign issue_adder = pop_adder || byp_adder;
  assign issue_other = pop_other || byp_other;
  assign issue_data  = pop ? head : InstrIn;

  always_ff @(posedge Clock) begin
    if (wr_en) mem[wr_ptr] <= InstrIn;
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count_q    <= '0;
      Adderin    <= 1'b0;
      AdderInstr <= '0;
      OtherValid <= 1'b0;
      OtherInstr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (pop)   rd_ptr <= rd_ptr + PW'(1);
      case ({wr_en, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase

      Adderin <= issue_adder;
      if (issue_adder) AdderInstr <= issue_data;

      if (issue_other) begin
        OtherValid <= 1'b1;
        OtherInstr <= issue_data;
      end else if (OtherReady) begin
        OtherValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_issue_queue.sv
// Randomized and directed bench for issue_queue against a queue-based reference model.
module tb_issue_queue;

  localparam int DEPTH = 8;

  logic        Clock;
  logic        Resetn;
  logic [15:0] InstrIn;
  logic        InstrValid;
  logic        InstrReady;
  logic [7:0]  Busy;
  logic [15:0] AdderInstr;
  logic        Adderin;
  logic [15:0] OtherInstr;
  logic        OtherValid;
  logic        OtherReady;
  logic [3:0]  Count;

  issue_queue #(.DEPTH(DEPTH), .INSTR_W(16)) dut (
    .Clock(Clock), .Resetn(Resetn), .InstrIn(InstrIn), .InstrValid(InstrValid),
    .InstrReady(InstrReady), .Busy(Busy), .AdderInstr(AdderInstr), .Adderin(Adderin),
    .OtherInstr(OtherInstr), .OtherValid(OtherValid), .OtherReady(OtherReady), .Count(Count)
  );

  // clock / reset
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_errors = 0;

  // reference model: queued instructions plus the two output stages
  logic [15:0] exp_q[$];
  logic        m_adderin, m_ovalid;
  logic [15:0] m_ainstr, m_oinstr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_adder(input logic [15:0] ins);
    return ins[15:12] < 4'h2;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_adderin = 1'b0;
    m_ovalid  = 1'b0;
    m_ainstr  = '0;
    m_oinstr  = '0;
  endtask

  // One clock edge of the model, using pre-edge state and inputs.
  task automatic model_edge(input logic v, input logic [15:0] ins, input logic [7:0] b,
                            input logic ordy);
    int          free;
    bit          do_push, new_adder, new_other, oacc;
    logic [15:0] val;
    free      = $countones(~b) - (m_adderin ? 1 : 0);
    if (free < 0) free = 0;
    do_push   = v && (exp_q.size() < DEPTH);
    oacc      = !m_ovalid || ordy;
    new_adder = 0;
    new_other = 0;
    val       = '0;
    if (exp_q.size() > 0) begin
      if (is_adder(exp_q[0])) begin
        if (free > 0) begin new_adder = 1; val = exp_q.pop_front(); end
      end else if (oacc) begin
        new_other = 1; val = exp_q.pop_front();
      end
    end
`ifdef ISSUEQ_BYPASS_EN
    else if (do_push) begin
      if (is_adder(ins) && free > 0) begin new_adder = 1; val = ins; do_push = 0; end
      else if (!is_adder(ins) && oacc) begin new_other = 1; val = ins; do_push = 0; end
    end
`endif
    if (do_push) exp_q.push_back(ins);
    m_adderin = new_adder;
    if (new_adder) m_ainstr = val;
    if (new_other) begin m_ovalid = 1'b1; m_oinstr = val; end
    else if (m_ovalid && ordy) m_ovalid = 1'b0;
  endtask

  task automatic compare_all(input string tag);
    check({tag, "_count"},  Count, exp_q.size());
    check({tag, "_ready"},  InstrReady, exp_q.size() != DEPTH);
    check({tag, "_adderin"}, Adderin, m_adderin);
    check({tag, "_ainstr"}, AdderInstr, m_ainstr);
    check({tag, "_ovalid"}, OtherValid, m_ovalid);
    check({tag, "_oinstr"}, OtherInstr, m_oinstr);
  endtask

  // driver: apply inputs, advance model and DUT by one edge, compare after the edge
  task automatic cycle(input logic v, input logic [15:0] ins, input logic [7:0] b,
                       input logic ordy, input string tag);
    InstrValid = v;
    InstrIn    = ins;
    Busy       = b;
    OtherReady = ordy;
    model_edge(v, ins, b, ordy);
    @(posedge Clock);
    #1;
    compare_all(tag);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40 && (exp_q.size() != 0 || m_ovalid || m_adderin); i++)
      cycle(1'b0, 16'h0, 8'h00, 1'b1, tag);
    check({tag, "_drained"}, exp_q.size() + m_ovalid, 0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_adderin"}, Adderin, 0);
    check({tag, "_ovalid"},  OtherValid, 0);
    check({tag, "_count"},   Count, 0);
    check({tag, "_ready"},   InstrReady, 1);
    check({tag, "_ainstr"},  AdderInstr, 0);
    check({tag, "_oinstr"},  OtherInstr, 0);
  endtask

  logic [15:0] fill_v[8];
  int          k;

  initial begin
    Resetn = 1'b0; InstrIn = '0; InstrValid = 1'b0; Busy = 8'h00; OtherReady = 1'b1;
    model_reset();
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    check_reset_values("rst");
    Resetn = 1'b1;

    // single ADD with an idle RS
    cycle(1'b1, 16'h0123, 8'h00, 1'b1, "t1a");
`ifndef ISSUEQ_BYPASS_EN
    check("t1_no_early_issue", Adderin, 0);
`endif
    cycle(1'b0, 16'h0, 8'h00, 1'b1, "t1b");
`ifndef ISSUEQ_BYPASS_EN
    check("t1_issue", Adderin, 1);
    check("t1_issue_data", AdderInstr, 16'h0123);
`endif
    cycle(1'b0, 16'h0, 8'h00, 1'b1, "t1c");
    check("t1_pulse_end", Adderin, 0);
    check("t1_count", Count, 0);

    // one free line: in-flight issue must be discounted
    cycle(1'b1, 16'h0a01, 8'hFE, 1'b1, "t2");
    cycle(1'b1, 16'h1a02, 8'hFE, 1'b1, "t2");
    cycle(1'b1, 16'h0a03, 8'hFE, 1'b1, "t2");
`ifndef ISSUEQ_BYPASS_EN
    check("t2_no_second_issue", Adderin, 0);
`endif
    repeat (3) cycle(1'b0, 16'h0, 8'hFF, 1'b1, "t2");
`ifndef ISSUEQ_BYPASS_EN
    check("t2_count_held", Count, 2);
`endif
    drain("t2");

    // fill to full across pointer wrap, overflow push ignored, ordered drain
    for (int i = 0; i < 8; i++) begin
      fill_v[i] = ((i % 2) ? 16'h1000 : 16'h0000) | 16'((i + 1) * 16'h0111);
      cycle(1'b1, fill_v[i], 8'hFF, 1'b1, "t3f");
    end
    check("t3_full_count", Count, 8);
    check("t3_full_ready", InstrReady, 0);
    cycle(1'b1, 16'h0fff, 8'hFF, 1'b1, "t3x");
    check("t3_overflow_count", Count, 8);
    k = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 16'h0, 8'h00, 1'b1, "t3d");
      if (Adderin && k < 8) begin
        check("t3_order", AdderInstr, fill_v[k]);
        k++;
      end
    end
    check("t3_all_consecutive", k, 8);
    drain("t3");

    // blocked other-class head stalls the ADD behind it
    cycle(1'b1, 16'h5abc, 8'h00, 1'b0, "t4");
    cycle(1'b1, 16'h6def, 8'h00, 1'b0, "t4");
    cycle(1'b1, 16'h0777, 8'h00, 1'b0, "t4");
    repeat (3) cycle(1'b0, 16'h0, 8'h00, 1'b0, "t4h");
    check("t4_held_valid", OtherValid, 1);
    check("t4_held_data", OtherInstr, 16'h5abc);
    check("t4_add_blocked", Count, 2);
    cycle(1'b0, 16'h0, 8'h00, 1'b1, "t4r");
    check("t4_next_other", OtherInstr, 16'h6def);
    cycle(1'b0, 16'h0, 8'h00, 1'b0, "t4a");
    check("t4_add_issue", AdderInstr, 16'h0777);

    // asynchronous reset with both output stages active
    check("t6_pre_adderin", Adderin, 1);
    check("t6_pre_ovalid", OtherValid, 1);
    #2;
    Resetn = 1'b0;
    InstrValid = 1'b0;
    #1;
    check_reset_values("t6");
    model_reset();
    @(negedge Clock);
    Resetn = 1'b1;

    // steady push/pop at DEPTH-1
    for (int i = 0; i < 7; i++) cycle(1'b1, 16'(16'h0200 + i), 8'hFF, 1'b1, "t5f");
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 16'($urandom_range(0, 16'h1fff)), 8'h00, 1'b1, "t5s");
      check("t5_count_const", Count, 7);
    end
    drain("t5");

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [15:0] ins;
      logic [7:0]  b;
      ins = 16'($urandom);
      if ($urandom_range(0, 2) != 0) ins[15:12] = 4'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: b = 8'h00;
        1: b = 8'hFF;
        2: b = 8'hFE;
        default: b = 8'($urandom);
      endcase
      cycle(1'($urandom_range(0, 1)), ins, b, 1'($urandom_range(0, 2) != 0), "rnd");
    end
    drain("rnd");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
